// File: rtl/sim_mem_pkg.sv
// Shared types and defaults for the simulation memory port arbiter.
// Contents:
//   arb_state_t  - arbiter FSM states (IDLE/ISSUE/WAIT/RESP)
//   req_id_t     - requester identity (REQ_INST=0, REQ_DATA=1)
//   DEF_*        - default widths and memory read latency
//   mem_req_t    - request payload at the default widths, for neighbours
//                  that exchange whole requests with the arbiter
package sim_mem_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MEM_LATENCY = 1;

  // Wide enough for the full legal latency range 1..15.
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_t;

  typedef struct packed {
    logic                      write;
    logic [DEF_DATA_W/8-1:0]   mark;
    logic [DEF_ADDR_W-1:0]     addr;
    logic [DEF_DATA_W-1:0]     wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic, purely combinational.
// Ports:
//   valid[1:0]  in   request pending; bit 0 = inst, bit 1 = data
//   last_grant  in   requester granted most recently (0 = inst, 1 = data)
//   enable      in   grants are only produced while enabled
//   grant[1:0]  out  one-hot grant (all zero when disabled or nothing valid)
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        // Contention: the side that was not served last time wins.
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        // Zero or one requester: grant follows valid directly.
        grant = valid;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered-read memory port between the instruction-fetch
// and data requesters. One transaction at a time: accept (IDLE), drive the
// memory for a single cycle (ISSUE), wait out the read latency (WAIT), then
// strobe the response to the owner for one cycle (RESP).
// Ports:
//   clock, reset               clock; asynchronous active-low reset
//   inst_req_* / inst_resp_*   instruction requester handshake and response
//   data_req_* / data_resp_*   data requester handshake and response
//   mem_*                      memory port (enables, mask, address, data)
//   busy                       high whenever the FSM is not IDLE
module mem_port_arbiter
  import sim_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                inst_req_valid,
  output logic                inst_req_ready,
  input  logic                inst_req_write,
  input  logic [DATA_W/8-1:0] inst_req_mark,
  input  logic [ADDR_W-1:0]   inst_req_addr,
  input  logic [DATA_W-1:0]   inst_req_wdata,
  output logic                inst_resp_valid,
  output logic [DATA_W-1:0]   inst_resp_rdata,

  input  logic                data_req_valid,
  output logic                data_req_ready,
  input  logic                data_req_write,
  input  logic [DATA_W/8-1:0] data_req_mark,
  input  logic [ADDR_W-1:0]   data_req_addr,
  input  logic [DATA_W-1:0]   data_req_wdata,
  output logic                data_resp_valid,
  output logic [DATA_W-1:0]   data_resp_rdata,

  output logic                mem_readEn,
  output logic                mem_writeEn,
  output logic [DATA_W/8-1:0] mem_mark,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_writeData,
  input  logic [DATA_W-1:0]   mem_readData,

  output logic                busy
);

  localparam int MARK_W = DATA_W / 8;

  // Parameter-width view of the request payload.
  typedef struct packed {
    logic              write;
    logic [MARK_W-1:0] mark;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_t            state_q,      state_d;
  req_t                  req_q,        req_d;
  req_id_t               owner_q,      owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic [DATA_W-1:0]     inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]     data_rdata_q, data_rdata_d;

  logic [1:0]            grant;
  logic                  arb_en;
  logic [DATA_W-1:0]     cap_data;

  // Gating with reset keeps ready low while reset is held, even though the
  // state register already sits in IDLE.
  assign arb_en = (state_q == IDLE) && reset;

  rr_arbiter2 u_rr_arbiter2 (
    .valid      ({data_req_valid, inst_req_valid}),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (grant)
  );

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    wait_cnt_d      = wait_cnt_q;
    inst_rdata_d    = inst_rdata_q;
    data_rdata_d    = data_rdata_q;
    cap_data        = '0;

    inst_req_ready  = grant[0];
    data_req_ready  = grant[1];
    inst_resp_valid = 1'b0;
    data_resp_valid = 1'b0;
    mem_readEn      = 1'b0;
    mem_writeEn     = 1'b0;
    mem_mark        = '0;
    mem_addr        = '0;
    mem_writeData   = '0;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d      = grant[1] ? REQ_DATA : REQ_INST;
          last_grant_d = grant[1];
          req_d        = grant[1]
                       ? '{write: data_req_write, mark: data_req_mark,
                           addr: data_req_addr, wdata: data_req_wdata}
                       : '{write: inst_req_write, mark: inst_req_mark,
                           addr: inst_req_addr, wdata: inst_req_wdata};
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        mem_readEn    = ~req_q.write;
        mem_writeEn   = req_q.write;
        mem_mark      = req_q.mark;
        mem_addr      = req_q.addr;
        mem_writeData = req_q.wdata;
        wait_cnt_d    = WAIT_CNT_W'(MEM_LATENCY);
        state_d       = WAIT;
      end

      WAIT: begin
        if (wait_cnt_q == WAIT_CNT_W'(1)) begin
          // Read data is valid now; writes report zero.
          cap_data = req_q.write ? '0 : mem_readData;
          if (owner_q == REQ_DATA) begin
            data_rdata_d = cap_data;
          end else begin
            inst_rdata_d = cap_data;
          end
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end

      RESP: begin
        inst_resp_valid = (owner_q == REQ_INST);
        data_resp_valid = (owner_q == REQ_DATA);
        state_d         = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      owner_q      <= REQ_INST;
      last_grant_q <= 1'b0;  // inst counts as last served, so data wins first
      wait_cnt_q   <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_resp_rdata = inst_rdata_q;
  assign data_resp_rdata = data_rdata_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances run side by side:
// index 0 with MEM_LATENCY=1, index 1 with MEM_LATENCY=3. A behavioural
// memory answers each memory port; a transaction-level reference model
// predicts ready/enables/response timing and data from the arbitration rules.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        v;
    logic        w;
    logic [3:0]  m;
    logic [31:0] a;
    logic [31:0] d;
  } rq_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n [2];
  rq_t  rq [2][2];  // [instance][0=inst,1=data]

  wire        rdy  [2][2];
  wire        rsv  [2][2];
  wire [31:0] rsd  [2][2];
  wire        ren  [2];
  wire        wen  [2];
  wire [3:0]  mm   [2];
  wire [31:0] ma   [2];
  wire [31:0] mwd  [2];
  wire        bsy  [2];

  logic [31:0] mem [2][16];
  logic [31:0] stg [2][3];

  for (genvar gk = 0; gk < 2; gk++) begin : g_dut
    localparam int L = (gk == 0) ? 1 : 3;
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) u_dut (
      .clock           (clock),
      .reset           (rst_n[gk]),
      .inst_req_valid  (rq[gk][0].v),
      .inst_req_ready  (rdy[gk][0]),
      .inst_req_write  (rq[gk][0].w),
      .inst_req_mark   (rq[gk][0].m),
      .inst_req_addr   (rq[gk][0].a),
      .inst_req_wdata  (rq[gk][0].d),
      .inst_resp_valid (rsv[gk][0]),
      .inst_resp_rdata (rsd[gk][0]),
      .data_req_valid  (rq[gk][1].v),
      .data_req_ready  (rdy[gk][1]),
      .data_req_write  (rq[gk][1].w),
      .data_req_mark   (rq[gk][1].m),
      .data_req_addr   (rq[gk][1].a),
      .data_req_wdata  (rq[gk][1].d),
      .data_resp_valid (rsv[gk][1]),
      .data_resp_rdata (rsd[gk][1]),
      .mem_readEn      (ren[gk]),
      .mem_writeEn     (wen[gk]),
      .mem_mark        (mm[gk]),
      .mem_addr        (ma[gk]),
      .mem_writeData   (mwd[gk]),
      .mem_readData    (stg[gk][L-1]),
      .busy            (bsy[gk])
    );
  end

  // Behavioural memory: byte-masked writes, read data through a delay line.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (wen[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (mm[k][b]) mem[k][ma[k][5:2]][8*b +: 8] <= mwd[k][8*b +: 8];
        end
      end
      if (ren[k]) stg[k][0] <= mem[k][ma[k][5:2]];
      stg[k][1] <= stg[k][0];
      stg[k][2] <= stg[k][1];
    end
  end

  // Reference model state.
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc [2];
  int          acc [2];     // cycle of last acceptance, -1 if none in flight
  int          owner [2];
  rq_t         accq [2];
  bit          lg [2];      // last granted: 0 inst, 1 data
  logic [31:0] exp_rd [2];
  logic [31:0] ref_mem [2][16];
  int          grant_log [$];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic new_req(input int k, input int r);
    rq[k][r].v = 1'b1;
    rq[k][r].w = 1'($urandom_range(0, 1));
    rq[k][r].m = 4'($urandom);
    rq[k][r].a = (r == 1 ? 32'h8000_1000 : 32'h8000_0000) | (32'($urandom_range(1, 15)) << 2);
    rq[k][r].d = $urandom;
  endtask

  task automatic set_req(input int k, input int r, input logic w, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] d);
    rq[k][r].v = 1'b1;
    rq[k][r].w = w;
    rq[k][r].m = m;
    rq[k][r].a = a;
    rq[k][r].d = d;
  endtask

  // One clock cycle on instance k. Entered at posedge+1; mode 0 = no new
  // requests, 1 = random arrivals, 2 = requesters re-raise immediately.
  task automatic step(input int k, input int mode);
    int    L = lat(k);
    int    win = -1;
    bit    free, issue, resp;
    string p;
    for (int r = 0; r < 2; r++) begin
      if (!rq[k][r].v && (mode == 2 || (mode == 1 && $urandom_range(0, 2) == 0)))
        new_req(k, r);
    end
    #1;
    p = $sformatf("k%0d c%0d", k, cyc[k]);
    free = (acc[k] < 0) || (cyc[k] >= acc[k] + L + 3);
    if (free) begin
      if (rq[k][0].v && rq[k][1].v) win = lg[k] ? 0 : 1;
      else if (rq[k][0].v)          win = 0;
      else if (rq[k][1].v)          win = 1;
    end
    issue = (acc[k] >= 0) && (cyc[k] == acc[k] + 1);
    resp  = (acc[k] >= 0) && (cyc[k] == acc[k] + L + 2);

    if (rdy[k][0] === 1'b1) grant_log.push_back(0);
    if (rdy[k][1] === 1'b1) grant_log.push_back(1);

    chk1({p, " inst_ready"}, rdy[k][0], win == 0);
    chk1({p, " data_ready"}, rdy[k][1], win == 1);
    chk1({p, " readEn"},  ren[k], issue && !accq[k].w);
    chk1({p, " writeEn"}, wen[k], issue &&  accq[k].w);
    chk32({p, " mem_addr"},  ma[k],  issue ? accq[k].a : 32'h0);
    chk32({p, " mem_mark"},  {28'h0, mm[k]}, issue ? {28'h0, accq[k].m} : 32'h0);
    chk32({p, " mem_wdata"}, mwd[k], issue ? accq[k].d : 32'h0);
    chk1({p, " inst_resp_valid"}, rsv[k][0], resp && owner[k] == 0);
    chk1({p, " data_resp_valid"}, rsv[k][1], resp && owner[k] == 1);
    if (resp) chk32({p, " resp_rdata"}, rsd[k][owner[k]], exp_rd[k]);
    chk1({p, " busy"}, bsy[k], (acc[k] >= 0) && (cyc[k] > acc[k]) && (cyc[k] <= acc[k] + L + 2));

    if (win >= 0) begin
      acc[k]   = cyc[k];
      owner[k] = win;
      accq[k]  = rq[k][win];
      lg[k]    = (win == 1);
      if (rq[k][win].w) begin
        exp_rd[k] = 32'h0;
        for (int b = 0; b < 4; b++)
          if (rq[k][win].m[b]) ref_mem[k][rq[k][win].a[5:2]][8*b +: 8] = rq[k][win].d[8*b +: 8];
      end else begin
        exp_rd[k] = ref_mem[k][rq[k][win].a[5:2]];
      end
      $display("[TB] k%0d cyc %0d accept %s %s addr=%h mark=%h wdata=%h",
               k, cyc[k], win ? "data" : "inst", rq[k][win].w ? "write" : "read",
               rq[k][win].a, rq[k][win].m, rq[k][win].d);
    end
    @(posedge clock);
    #1;
    if (win >= 0) rq[k][win].v = 1'b0;
    cyc[k]++;
  endtask

  task automatic drain(input int k);
    int guard = 0;
    while ((rq[k][0].v || rq[k][1].v || (acc[k] >= 0 && cyc[k] <= acc[k] + lat(k) + 2))
           && guard < 200) begin
      step(k, 0);
      guard++;
    end
    chk1($sformatf("k%0d drain_bound", k), guard < 200, 1'b1);
  endtask

  task automatic reset_chk(input int k, input string tag);
    chk1({tag, " busy"},        bsy[k],    1'b0);
    chk1({tag, " inst_ready"},  rdy[k][0], 1'b0);
    chk1({tag, " data_ready"},  rdy[k][1], 1'b0);
    chk1({tag, " readEn"},      ren[k],    1'b0);
    chk1({tag, " writeEn"},     wen[k],    1'b0);
    chk1({tag, " inst_resp"},   rsv[k][0], 1'b0);
    chk1({tag, " data_resp"},   rsv[k][1], 1'b0);
    chk32({tag, " inst_rdata"}, rsd[k][0], 32'h0);
    chk32({tag, " data_rdata"}, rsd[k][1], 32'h0);
    chk32({tag, " mem_addr"},   ma[k],     32'h0);
  endtask

  task automatic model_reset(input int k);
    acc[k] = -1;
    lg[k]  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      cyc[k] = 0; owner[k] = 0; exp_rd[k] = 32'h0; accq[k] = '0;
      model_reset(k);
      for (int r = 0; r < 2; r++) rq[k][r] = '0;
      for (int i = 0; i < 16; i++) begin
        mem[k][i] = $urandom;
        ref_mem[k][i] = mem[k][i];
      end
      for (int s = 0; s < 3; s++) stg[k][s] = 32'h0;
    end
    mem[0][0] = 32'h0000_0413; ref_mem[0][0] = 32'h0000_0413;
    mem[1][5] = 32'h1234_5678; ref_mem[1][5] = 32'h1234_5678;

    // Reset state, with requests pending to show ready stays low.
    repeat (2) @(posedge clock);
    #1;
    set_req(0, 0, 1'b0, 4'hF, 32'h8000_0000, 32'h0);
    set_req(1, 1, 1'b0, 4'hF, 32'h8000_1000, 32'h0);
    #1;
    reset_chk(0, "k0 reset");
    reset_chk(1, "k1 reset");
    rq[0][0].v = 1'b0;
    rq[1][1].v = 1'b0;
    @(posedge clock);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Contention straight after reset: data, inst, data.
    set_req(0, 0, 1'b0, 4'hF, 32'h8000_0004, 32'h0);
    set_req(0, 1, 1'b0, 4'hF, 32'h8000_1008, 32'h0);
    grant_log.delete();
    for (int i = 0; i < 13; i++) step(0, 2);
    drain(0);
    chk1("contention log size", grant_log.size() >= 3, 1'b1);
    if (grant_log.size() >= 3) begin
      chk32("contention grant0", 32'(grant_log[0]), 32'd1);
      chk32("contention grant1", 32'(grant_log[1]), 32'd0);
      chk32("contention grant2", 32'(grant_log[2]), 32'd1);
    end

    // Single read returning 0x413.
    set_req(0, 0, 1'b0, 4'hF, 32'h8000_0000, 32'h0);
    drain(0);
    // Masked write, then read back through the aliased word.
    set_req(0, 1, 1'b1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF);
    drain(0);
    set_req(0, 0, 1'b0, 4'b0000, 32'h8000_0000, 32'h0);
    drain(0);

    // Request raised in the RESP cycle waits for the following IDLE cycle.
    set_req(0, 0, 1'b0, 4'hF, 32'h8000_000C, 32'h0);
    for (int i = 0; i < lat(0) + 2; i++) step(0, 0);
    set_req(0, 1, 1'b0, 4'hF, 32'h8000_1010, 32'h0);
    drain(0);

    for (int i = 0; i < 400; i++) step(0, 1);
    drain(0);

    // MEM_LATENCY=3 read returning 0x12345678.
    set_req(1, 0, 1'b0, 4'hF, 32'h8000_0014, 32'h0);
    drain(1);

    // Reset in the middle of WAIT drops the transaction.
    set_req(1, 0, 1'b0, 4'hF, 32'h8000_0018, 32'h0);
    step(1, 0);
    step(1, 0);
    set_req(1, 1, 1'b0, 4'hF, 32'h8000_1020, 32'h0);
    rst_n[1] = 1'b0;
    #1;
    reset_chk(1, "k1 midwait");
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk1($sformatf("k1 held reset %0d busy", i), bsy[1], 1'b0);
      chk1($sformatf("k1 held reset %0d inst_resp", i), rsv[1][0], 1'b0);
      chk1($sformatf("k1 held reset %0d data_resp", i), rsv[1][1], 1'b0);
    end
    rst_n[1] = 1'b1;
    model_reset(1);
    set_req(1, 0, 1'b0, 4'hF, 32'h8000_0014, 32'h0);
    grant_log.delete();
    drain(1);
    chk1("k1 post-reset log size", grant_log.size() >= 2, 1'b1);
    if (grant_log.size() >= 2) begin
      chk32("k1 post-reset grant0", 32'(grant_log[0]), 32'd1);
      chk32("k1 post-reset grant1", 32'(grant_log[1]), 32'd0);
    end

    for (int i = 0; i < 400; i++) step(1, 1);
    drain(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one simulation memory port (DPI-backed pmem model, registered read data) between the CPU instruction-fetch requester and the data-access requester.
- Sits between `CPUTop` and a single memory model instance in the simulation top.
- Accepts one request at a time with a valid/ready handshake, issues it to memory for exactly one cycle, waits the memory read latency, then returns a one-cycle response to the winning requester.
- Arbitration between the two requesters is round-robin.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; mark width is DATA_W/8.
- MEM_LATENCY, 1, cycles from the issue edge to valid mem_readData; legal range 1..15.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- inst_req_valid  in  1  instruction request pending.
- inst_req_ready  out  1  instruction request accepted this cycle.
- inst_req_write  in  1  1 = write, 0 = read.
- inst_req_mark  in  DATA_W/8  byte mask.
- inst_req_addr  in  ADDR_W  address.
- inst_req_wdata  in  DATA_W  write data.
- inst_resp_valid  out  1  one-cycle response strobe.
- inst_resp_rdata  out  DATA_W  read data; 0 for writes.
- data_req_*, data_resp_*  same set as inst_*, for the data requester.
- mem_readEn  out  1  memory read enable.
- mem_writeEn  out  1  memory write enable.
- mem_mark  out  DATA_W/8  byte mask to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_writeData  out  DATA_W  write data to memory.
- mem_readData  in  DATA_W  registered read data from memory.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, the arbiter picks a winner and drives that requester's req_ready = 1 combinationally.
  - The request (write, mark, addr, wdata, owner id) is captured into registers at the edge.
  - Next state is ISSUE.
  - Ready is never high in any other state.
- ISSUE (1 cycle):
  - mem_addr, mem_mark and mem_writeData are driven from the captured registers.
  - mem_readEn = ~write and mem_writeEn = write; these are mutually exclusive.
  - Next state is WAIT with wait_cnt = MEM_LATENCY.
- WAIT:
  - Memory enables are 0.
  - wait_cnt decrements each cycle.
  - On the edge where wait_cnt == 1, mem_readData is captured into the response register (0 for writes), and the next state is RESP.
- RESP (1 cycle):
  - The owner's resp_valid = 1 with resp_rdata = captured data.
  - The other requester's resp_valid stays 0.
  - Next state is IDLE. No new request is accepted in the RESP cycle.
- Latency: accept edge to resp_valid is MEM_LATENCY+2 cycles. Throughput is one transaction per MEM_LATENCY+3 cycles.
- Round-robin:
  - last_grant register, 1 bit.
  - With both requesters valid, the requester that was not last granted wins.
  - With a single valid requester, it wins regardless of last_grant.
  - last_grant updates only on acceptance.
- Requester rules:
  - A requester holds valid and payload stable until ready.
  - A requester may raise its next valid during WAIT/RESP; that request is accepted in the next IDLE.
- Reset (reset == 0, any state, including mid-transaction):
  - State returns to IDLE immediately.
  - All outputs go to 0: ready, resp_valid, resp_rdata, all mem_* outputs, busy.
  - last_grant resets to inst, so the first contention goes to data.
  - An in-flight transaction is dropped with no response.
  - The first acceptance is possible in the first cycle after reset deassertion.
- Outside ISSUE, mem_addr, mem_mark and mem_writeData are driven as 0, not held.
- Masks: mark is forwarded unchanged, including 4'b0000. A read forwards mark unchanged as well.
- resp_rdata holds its last value between strobes. It is valid only with resp_valid.

Decomposition:
- Shared package `sim_mem_pkg`:
  - `arb_state_t` enum (IDLE/ISSUE/WAIT/RESP).
  - `req_id_t` (REQ_INST=0, REQ_DATA=1).
  - Default MEM_LATENCY.
  - A `mem_req_t` struct (write, mark, addr, wdata).
- One sub-module, `rr_arbiter2`:
  - Inputs: two valid bits, last_grant, enable.
  - Outputs: one-hot grant.
  - Purely combinational; last_grant is kept in the parent.

Test Plan:
- Single read: inst read addr 0x80000000, memory returns 0x00000413 → inst_req_ready at cycle 0, mem_readEn high only in cycle 1, inst_resp_valid at cycle 3 with rdata 0x00000413; data_resp_valid stays 0.
- Write: data write addr 0x80001000, wdata 0xDEADBEEF, mark 4'b0011 → mem_writeEn=1, mem_readEn=0, mem_mark=0011 for exactly one cycle; data_resp_valid at cycle 3 with rdata 0.
- Contention, first after reset: both valid in the same cycle → data wins first. Next, inst is granted while data still requests (round-robin). Then data again. There are no back-to-back data grants while inst is pending.
- MEM_LATENCY=3: read returning 0x12345678 → resp_valid exactly 5 cycles after accept; mem_readEn high for exactly 1 cycle.
- Reset during WAIT: reset asserted low mid-WAIT → busy=0 and mem enables=0 immediately; no resp_valid; after release, a new inst read completes normally with the correct latency.
- Requester raises valid during RESP → ready is not asserted in RESP; accepted on the following IDLE cycle.
